// File: rtl/spike_event_queue_pkg.sv
// Shared types for the spike event queue: event word layout and drop saturation limit.
package spike_pkg;

  localparam int unsigned STATE_W  = 8;
  localparam int unsigned TS_W_MAX = 32;
  localparam logic [7:0]  DROP_MAX = 8'hFF;

  // ts is sized for the widest supported counter; narrower builds zero-extend.
  typedef struct packed {
    logic [TS_W_MAX-1:0] ts;
    logic [STATE_W-1:0]  state;
  } spike_evt_t;

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous event FIFO; a push into a full queue is accepted only alongside a pop.
module spike_evt_fifo
  import spike_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  spike_evt_t               din,
  input  logic                     pop,
  output spike_evt_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  spike_evt_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  always_comb begin
    full    = (level == LW'(DEPTH));
    empty   = (level == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    // Head reads as zero while empty so the outputs match their reset values.
    dout    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_queue.sv
// Spike edge detector, timestamping and event queue with drop accounting.
// Optional refractory gating is enabled by defining SPIKE_REFRACTORY_EN.
module spike_event_queue
  import spike_pkg::*;
#(
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned REFRAC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spike_in,
  input  logic [7:0]                 state_in,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_timestamp,
  output logic [7:0]                 evt_state,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  logic [TS_W-1:0] ts_cnt;
  logic            spike_prev;
  logic            detect;
  logic            cand;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  spike_evt_t      push_word;
  spike_evt_t      head;
  logic            unused_head_hi;

  assign detect = spike_in & ~spike_prev;

`ifdef SPIKE_REFRACTORY_EN
  localparam int unsigned RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  logic [RW-1:0] refrac_cnt;

  assign cand = detect && (refrac_cnt == '0);

  // Reloaded on any candidate, whether it ends up queued or dropped.
  always_ff @(posedge clk) begin
    if (!rst_n)                  refrac_cnt <= '0;
    else if (cand)               refrac_cnt <= RW'(REFRAC);
    else if (refrac_cnt != '0)   refrac_cnt <= refrac_cnt - RW'(1);
  end
`else
  localparam int unsigned unused_refrac = REFRAC;
  assign cand = detect;
`endif

  always_comb begin
    push_word       = '0;
    push_word.ts    = TS_W_MAX'(ts_cnt);
    push_word.state = state_in;
    evt_valid       = !empty;
    pop             = evt_valid && evt_ready;
    drop            = cand && full && !pop;
    evt_timestamp   = head.ts[TS_W-1:0];
    evt_state       = head.state;
    unused_head_hi  = ^head.ts;
  end

  spike_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cand),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt     <= '0;
      spike_prev <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts_cnt     <= ts_cnt + TS_W'(1);
      spike_prev <= spike_in;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != DROP_MAX) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spike_event_queue.sv
// Scoreboard bench for spike_event_queue: a 16-bit timestamp instance and a 4-bit wrap instance.
module tb_spike_event_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        spike_a, ready_a;
  logic [7:0]  state_a;
  logic        valid_a, ovf_a;
  logic [15:0] ts_a;
  logic [7:0]  st_a, drop_a;
  logic [3:0]  lvl_a;

  logic        spike_b, ready_b;
  logic [7:0]  state_b;
  logic        valid_b, ovf_b;
  logic [3:0]  ts_b;
  logic [7:0]  st_b, drop_b;
  logic [3:0]  lvl_b;

  int total = 0;
  int bad   = 0;

  logic [23:0] q_a[$];
  logic [11:0] q_b[$];

  logic [15:0] tsm_a;
  logic [3:0]  tsm_b;

  spike_event_queue #(.TS_W(16), .DEPTH(8), .REFRAC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_a), .state_in(state_a),
    .evt_valid(valid_a), .evt_ready(ready_a), .evt_timestamp(ts_a),
    .evt_state(st_a), .fifo_level(lvl_a), .overflow(ovf_a), .drop_count(drop_a)
  );

  spike_event_queue #(.TS_W(4), .DEPTH(8), .REFRAC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_b), .state_in(state_b),
    .evt_valid(valid_b), .evt_ready(ready_b), .evt_timestamp(ts_b),
    .evt_state(st_b), .fifo_level(lvl_b), .overflow(ovf_b), .drop_count(drop_b)
  );

  // Free-running timestamp reference: value that the next posedge would capture.
  always @(posedge clk) begin
    if (!rst_n) begin
      tsm_a <= 16'd0;
      tsm_b <= 4'd0;
    end else begin
      tsm_a <= tsm_a + 16'd1;
      tsm_b <= tsm_b + 4'd1;
    end
  end

  always @(negedge clk) begin
    logic [23:0] exp;
    if (rst_n === 1'b1 && valid_a === 1'b1 && ready_a === 1'b1) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL pop_a: unexpected event ts=%0d state=%h", ts_a, st_a);
      end else begin
        exp = q_a.pop_front();
        if ({ts_a, st_a} !== exp) begin
          bad++;
          $display("FAIL pop_a: got ts=%0d state=%h expected ts=%0d state=%h",
                   ts_a, st_a, exp[23:8], exp[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] exp;
    if (rst_n === 1'b1 && valid_b === 1'b1 && ready_b === 1'b1) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL pop_b: unexpected event ts=%0d state=%h", ts_b, st_b);
      end else begin
        exp = q_b.pop_front();
        if ({ts_b, st_b} !== exp) begin
          bad++;
          $display("FAIL pop_b: got ts=%0d state=%h expected ts=%0d state=%h",
                   ts_b, st_b, exp[11:8], exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_a(input logic [7:0] s, input bit expect_push);
    spike_a = 1'b1;
    state_a = s;
    if (expect_push) q_a.push_back({tsm_a, s});
    tick();
    spike_a = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid_a), 32'd0);
    check({tag, "_ts"},    32'(ts_a),    32'd0);
    check({tag, "_state"}, 32'(st_a),    32'd0);
    check({tag, "_level"}, 32'(lvl_a),   32'd0);
    check({tag, "_ovf"},   32'(ovf_a),   32'd0);
    check({tag, "_drop"},  32'(drop_a),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    spike_a = 1'b0; state_a = 8'h00; ready_a = 1'b0;
    spike_b = 1'b0; state_b = 8'h00; ready_b = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Test 1: rising edge captured at ts=5, visible one cycle later
    for (int i = 0; i < 20 && tsm_a != 16'd5; i++) tick();
    spike_a = 1'b1;
    state_a = 8'h80;
    q_a.push_back({16'd5, 8'h80});
    check("t1_valid_before", 32'(valid_a), 32'd0);
    tick();
    check("t1_valid", 32'(valid_a), 32'd1);
    check("t1_ts",    32'(ts_a),    32'd5);
    check("t1_state", 32'(st_a),    32'h80);
    check("t1_level", 32'(lvl_a),   32'd1);

    // Test 2: level held high 10 cycles gives one event
    ready_a = 1'b1;
    repeat (9) tick();
    check("t2_level", 32'(lvl_a),   32'd0);
    check("t2_valid", 32'(valid_a), 32'd0);
    spike_a = 1'b0;
    tick();

    // Test 5: 4-bit timestamp wrap on the second instance
    for (int i = 0; i < 40 && tsm_b != 4'd15; i++) tick();
    spike_b = 1'b1; state_b = 8'hF0;
    q_b.push_back({4'd15, 8'hF0});
    tick();
    spike_b = 1'b0;
    for (int i = 0; i < 40 && tsm_b != 4'd1; i++) tick();
    spike_b = 1'b1; state_b = 8'h01;
    q_b.push_back({4'd1, 8'h01});
    tick();
    spike_b = 1'b0;
    repeat (4) tick();
    check("t5_level_b", 32'(lvl_b), 32'd0);

    // Test 3: nine edges into a stalled queue, ninth is dropped
    ready_a = 1'b0;
    for (int i = 0; i < 9; i++) edge_a(8'h10 + 8'(i), i < 8);
    check("t3_level", 32'(lvl_a),  32'd8);
    check("t3_ovf",   32'(ovf_a),  32'd1);
    check("t3_drop",  32'(drop_a), 32'd1);
    check("t3_head",  32'(st_a),   32'h10);

    // Test 4: full queue, pop and new edge together
    ready_a = 1'b1;
    spike_a = 1'b1;
    state_a = 8'hAA;
    q_a.push_back({tsm_a, 8'hAA});
    tick();
    ready_a = 1'b0;
    spike_a = 1'b0;
    check("t4_level", 32'(lvl_a),  32'd8);
    check("t4_drop",  32'(drop_a), 32'd1);
    tick();
    ready_a = 1'b1;
    for (int i = 0; i < 20 && lvl_a != 4'd0; i++) tick();
    ready_a = 1'b0;
    check("t4_drained", 32'(lvl_a), 32'd0);
    check("t4_ovf_sticky", 32'(ovf_a), 32'd1);

    // Test 6: reset mid-operation
    for (int i = 0; i < 3; i++) edge_a(8'h33, 1'b0);
    check("t6_level", 32'(lvl_a), 32'd3);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6");
    rst_n = 1'b1;
    tick();
    check("t6_valid_after", 32'(valid_a), 32'd0);

    // Edges two cycles apart: refractory window suppresses the second
    ready_a = 1'b1;
    edge_a(8'h41, 1'b1);
`ifdef SPIKE_REFRACTORY_EN
    edge_a(8'h42, 1'b0);
`else
    edge_a(8'h42, 1'b1);
`endif
    repeat (6) tick();
    check("refrac_level", 32'(lvl_a),  32'd0);
    check("refrac_drop",  32'(drop_a), 32'd0);

    check("sb_a_empty", 32'(q_a.size()), 32'd0);
    check("sb_b_empty", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
